// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words into IMEM and holds the core in reset until a full image lands.
// Optional trailing XOR checksum byte enabled by defining LDR_CHKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so that a full DEPTH-word image terminates without wrapping.
  localparam int unsigned IDX_W = ADDR_W + 1;

`ifdef LDR_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_DONE, S_ERR} state_e;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_q, core_rst_d;
`ifdef LDR_CHKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif
  logic              accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef LDR_CHKSUM_EN
    acc_d      = acc_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_COUNT;
          word_idx_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
`ifdef LDR_CHKSUM_EN
          acc_d      = '0;
`endif
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            n_d     = IDX_W'(in_data);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LDR_CHKSUM_EN
          acc_d = acc_q ^ in_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              we_d       = 1'b1;
              waddr_d    = word_idx_q[ADDR_W-1:0];
              wdata_d    = {in_data, asm_q};
              word_idx_d = word_idx_q + IDX_W'(1);
              if (word_idx_d == n_q) begin
`ifdef LDR_CHKSUM_EN
                state_d = S_CHECK;
`else
                state_d = S_DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef LDR_CHKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA)
`ifdef LDR_CHKSUM_EN
                 || (state_d == S_CHECK)
`endif
                 ;
    busy_d     = in_ready_d;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RN) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef LDR_CHKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
`ifdef LDR_CHKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the core's 32-word instruction memory from a byte stream before execution. It accepts a length-prefixed, little-endian byte stream on a valid/ready interface and assembles 32-bit instruction words. It drives a one-word-per-cycle write port into IMEM and holds the pipelined core in reset until a complete, valid image has been written. It sits between the host/debug byte link and the core's IMEM write side.

## Interface
Parameters:
- DEPTH, 32, number of IMEM words; legal image length is 1..DEPTH
- ADDR_W, 5, IMEM word-address width; DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock, all state on rising edge
- RN  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  loader accepts a byte this cycle
- we  out  1  IMEM write strobe, one cycle per word
- waddr  out  ADDR_W  IMEM word address
- wdata  out  32  IMEM write word
- core_rst  out  1  active-high reset to the core (matches core's reset polarity)
- busy  out  1  load in progress
- done  out  1  image loaded successfully
- err  out  1  load rejected

## Operation
- Byte transfer occurs when in_valid && in_ready are both high at a rising edge. in_ready is a function of state only: high in COUNT, DATA and CHECK; low elsewhere.
- Stream format: byte 0 is N, the word count. It is followed by 4·N data bytes per word, LSB first. With LDR_CHKSUM_EN, one checksum byte follows.
- States:
  - IDLE
    - start → COUNT. Clear word index, byte index and XOR accumulator.
  - COUNT
    - Accept N. N==0 or N>DEPTH → ERR.
    - Otherwise latch N → DATA.
  - DATA
    - Each accepted byte shifts into assembly register bits [8·k+7:8·k], where k = byte index 0..3.
    - Each accepted byte is XORed into the accumulator.
    - On k==3: next cycle we=1, waddr = word index, wdata = assembled word. Word index increments; k wraps to 0.
    - After word N−1 is accepted → CHECK (macro on) or DONE (macro off).
  - CHECK
    - Accepted byte == accumulator → DONE, otherwise → ERR.
  - DONE
    - done=1, core_rst=0, held until start.
  - ERR
    - err=1, core_rst=1, held until start.
- busy=1 in COUNT/DATA/CHECK.
- core_rst=1 in every state except DONE.
- start is ignored while busy.
- start in DONE/ERR clears done/err, reasserts core_rst, → COUNT.
- Words already written before an ERR stay in IMEM. The loader never clears IMEM.
- Word index is ADDR_W+1 bits wide so that N==DEPTH terminates without wrap-around.

## Timing
- Reset (RN low at an edge):
  - state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, core_rst=1, busy=0, done=0, err=0.
  - Assembly register, indices and accumulator are cleared.
- Reset mid-load aborts immediately. No partial-word write is issued.
- start sampled at edge T → in_ready=1 from T+1.
- 4th byte of a word accepted at edge T → we=1 for exactly the cycle T+1..T+2 with stable waddr/wdata. in_ready stays high, so the next byte can be accepted at T+1 (full throughput, 1 byte/cycle).
- Last byte (data or checksum) accepted at edge T → state DONE/ERR and flags valid from T+1. The final we and the DONE state may coincide. core_rst falls in the same cycle done rises.
- in_valid gaps of any length stall the state machine without data loss.
- Bytes presented while in_ready=0 are not consumed.

## Configuration
- LDR_CHKSUM_EN
  - Defined: CHECK state present. A trailing XOR-of-all-data-bytes checksum is required; a mismatch → ERR.
  - Undefined: no CHECK state and no accumulator; DONE directly after the last word's write.

## Test plan
- N=2, bytes 00 83 20 02, 80 93 20 02 (macro off) → we at waddr 0 with 32'h02208300 and waddr 1 with 32'h02209380; done=1, core_rst=0 on the cycle after the 8th byte.
- N=0, then N=33 (each after start) → err=1, no we pulses, core_rst stays 1.
- Macro on, N=1, word 32'h00f00002, checksum byte 8'hF2 → done=1. Repeat with checksum 8'hF3 → err=1 after the word write at waddr 0.
- N=32 with random in_valid gaps → exactly 32 we pulses at waddr 0..31 in order, correct data, done=1.
- Reset (RN=0) asserted after 6 data bytes of N=3 → only the word at waddr 0 written, all outputs at reset values next cycle. start then reloads cleanly.
- start pulsed during DATA → ignored, load completes unchanged. start in DONE → done=0, core_rst=1, new load begins.
